fifo_ram: RTL and testbench
===========================

FIFO_RAM -- requirements
Module: fifo_ram

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; reset port named reset, clock port named clock.
REQ-002 Parameter DATA_WIDTH, default 8, data word width in bits.
REQ-003 Parameter ADDR_WIDTH, default 14, address width; DEPTH = 2^ADDR_WIDTH (16384 words).
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 data_in  input  DATA_WIDTH  write data.
REQ-007 read  input  1  read request.
REQ-008 write  input  1  write request.
REQ-009 enable  input  1  global enable; read and write requests are ignored while low.
REQ-010 data_out  output  DATA_WIDTH  registered read data.
REQ-011 full  output  1  high when the FIFO holds DEPTH words.
REQ-012 empty  output  1  high when the FIFO holds 0 words.

Function
REQ-013 SHALL store words in an internal DEPTH x DATA_WIDTH RAM with ADDR_WIDTH-bit write and read pointers and an (ADDR_WIDTH+1)-bit occupancy count.
REQ-014 Write accepted on the rising edge when enable=1, write=1 and full=0: RAM[wr_ptr] <= data_in; wr_ptr increments.
REQ-015 Read accepted on the rising edge when enable=1, read=1 and empty=0: data_out <= RAM[rd_ptr]; rd_ptr increments; data valid the cycle after acceptance (1-cycle latency).
REQ-016 data_out SHALL hold its last value when no read is accepted.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 by natural modulo-2^ADDR_WIDTH overflow.
REQ-018 count increments on write-only acceptance, decrements on read-only acceptance, unchanged when both or neither are accepted.
REQ-019 Simultaneous read and write with 0 < count < DEPTH: both accepted in the same edge.
REQ-020 Simultaneous read and write when empty: only the write accepted; data_out unchanged.
REQ-021 Simultaneous read and write when full: only the read accepted; write data dropped.
REQ-022 Write while full, or read while empty: ignored with no state change (except REQ-031 flags).
REQ-023 full = (count == DEPTH), empty = (count == 0); both derived combinationally from the registered count.
REQ-024 enable=0 SHALL freeze all state regardless of read/write.

Reset
REQ-025 While reset=0: wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, asynchronously, irrespective of clock.
REQ-026 RAM contents SHALL NOT be reset; stale data is never observable because empty=1.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; first write after release lands at address 0.

Configuration
REQ-028 Macro FIFO_RAM_ERR_FLAGS_EN selects error-flag outputs.
REQ-029 With FIFO_RAM_ERR_FLAGS_EN defined: additional outputs overflow (1 bit) and underflow (1 bit) exist.
REQ-030 Without it: those ports and their logic are absent; all other behaviour identical.
REQ-031 overflow sets on any rising edge where enable=1, write=1, full=1 and no read is accepted; underflow sets where enable=1, read=1, empty=1; both sticky until reset, reset value 0.

Verification
REQ-032 Reset then idle: empty=1, full=0, data_out=0; enable=0 with write=1 for 10 cycles -> empty stays 1.
REQ-033 enable=1, write 0x01..0x32 (50 words), then read 50 -> data_out 0x01..0x32 in order, each one cycle after its read edge; empty=1 at end.
REQ-034 Write 16384 words (value = index mod 256) -> full=1 after last; extra write 0xAA ignored (overflow=1 when macro enabled); read all -> values match, 0xAA never appears.
REQ-035 Read while empty -> data_out unchanged, empty=1 (underflow=1 when macro enabled).
REQ-036 With 5 words stored, assert read and write together for 10 cycles -> count stays 5, outputs in FIFO order; then fill across the wrap boundary (wr_ptr 16383->0) and drain -> order preserved.
REQ-037 Write 3 words, assert reset=0 mid-cycle -> empty=1, data_out=0 immediately; after release write 0x55, read -> 0x55.

Source files
------------

// File: rtl/fifo_ram.sv
// Single-clock FIFO over a 2^ADDR_WIDTH x DATA_WIDTH RAM with registered read data.
// Define FIFO_RAM_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    input  logic                  write,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_RAM_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A full FIFO refuses the write even if a read frees a slot this edge.
    assign wr_ok = enable && write && !full;
    assign rd_ok = enable && read && !empty;

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FIFO_RAM_ERR_FLAGS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (enable && write && full && !rd_ok) begin
                overflow <= 1'b1;
            end
            if (enable && read && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ram.sv
// Self-checking bench for fifo_ram: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fifo_ram;

    localparam int DEPTH = 16384;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef FIFO_RAM_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    fifo_ram dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .read     (read),
        .write    (write),
        .enable   (enable),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef FIFO_RAM_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: a queue of words plus the last word read out.
    logic [7:0] q[$];
    logic [7:0] exp_do = '0;
    logic       exp_ovf = 1'b0;
    logic       exp_udf = 1'b0;

    typedef struct {
        logic       en;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       emp;
        logic       ful;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("data_out", 32'(data_out), 32'(exp_do));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
`ifdef FIFO_RAM_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_udf));
`endif
    endtask

    // One clock: drive inputs, update the model on the edge, sample 1ns later.
    task automatic cyc(input logic en, input logic wr, input logic rd,
                       input logic [7:0] din);
        bit acc_w;
        bit acc_r;
        bit is_full;
        enable  = en;
        write   = wr;
        read    = rd;
        data_in = din;
        @(posedge clock);
        is_full = (q.size() == DEPTH);
        acc_w = en && wr && !is_full;
        acc_r = en && rd && (q.size() > 0);
        if (en && wr && is_full && !acc_r) exp_ovf = 1'b1;
        if (en && rd && q.size() == 0) exp_udf = 1'b1;
        if (acc_r) exp_do = q.pop_front();
        if (acc_w) q.push_back(din);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        write  = 1'b0;
        read   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        q.delete();
        exp_do  = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        check_model();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        // en wr rd din  -> dout emp ful
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h22, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h55, 8'h33, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h66, 8'h55, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h66, 1'b1, 1'b0};

        // Asynchronous reset state, before any clock edge.
        #3;
        check("por_data_out", 32'(data_out), 32'h0);
        check("por_empty", 32'(empty), 32'h1);
        check("por_full", 32'(full), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Disabled writes leave the FIFO empty.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(i + 1));
            check("dis_empty", 32'(empty), 32'h1);
        end

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].en, tbl[i].wr, tbl[i].rd, tbl[i].din);
            check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].ful));
            check_model();
        end

        // 50 words in, 50 out, in order.
        for (int i = 1; i <= 50; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(i));
        end
        for (int i = 1; i <= 50; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'h00);
            check("order50", 32'(data_out), 32'(i));
        end
        check("order50_empty", 32'(empty), 32'h1);

        // Fill to capacity, write once more while full, then drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(i));
        end
        check("fill_full", 32'(full), 32'h1);
        check("fill_empty", 32'(empty), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 8'hAA);
        check_model();
`ifdef FIFO_RAM_ERR_FLAGS_EN
        check("ovf_set", 32'(overflow), 32'h1);
`endif
        // Read+write while full: only the read goes through.
        cyc(1'b1, 1'b1, 1'b1, 8'hAA);
        check("full_rw_dout", 32'(data_out), 32'h00);
        check_model();
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'h00);
            check("drain", 32'(data_out), 32'(i % 256));
        end
        check("drain_empty", 32'(empty), 32'h1);
        check_model();

        // Read while empty leaves data_out alone.
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("udf_dout", 32'(data_out), 32'hFF);
        check_model();
`ifdef FIFO_RAM_ERR_FLAGS_EN
        check("udf_set", 32'(underflow), 32'h1);
`endif

        // Walk pointers near the top, then stream across the wrap point.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH - 10; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 8'(i + 1));
        end
        check_model();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'hC0 + 8'(i));
        end
        check("five_stored", 32'(q.size()), 32'd5);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 8'hD0 + 8'(i));
            check_model();
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'hE0 + 8'(i));
        end
        check_model();
        while (q.size() > 0) begin
            cyc(1'b1, 1'b0, 1'b1, 8'h00);
            check_model();
        end
        check("wrap_last", 32'(data_out), 32'hF3);

        // Reset mid-operation discards contents.
        cyc(1'b1, 1'b1, 1'b0, 8'hA1);
        cyc(1'b1, 1'b1, 1'b0, 8'hA2);
        cyc(1'b1, 1'b1, 1'b0, 8'hA3);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("pre_rst_dout", 32'(data_out), 32'hA1);
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("post_rst_dout", 32'(data_out), 32'h55);
        check_model();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom));
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
